// File: rtl/m92_pkg.sv
// -----------------------------------------------------------------------------
// m92_pkg
// Shared types for the CPU-side SDRAM responder.
//   cpu_sdr_state_e : responder FSM states
//   cpu_sdr_req_t   : request fields latched for the SDRAM CPU channel
// No ports (package).
// -----------------------------------------------------------------------------
package m92_pkg;

  localparam int M92_DATA_W = 16;
  localparam int M92_ADDR_W = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } cpu_sdr_state_e;

  typedef struct packed {
    logic [M92_ADDR_W-1:0] addr;
    logic [1:0]            be;
    logic [M92_DATA_W-1:0] wdata;
    logic                  we;
  } cpu_sdr_req_t;

endpackage

// File: rtl/cpu_rd_cache.sv
// -----------------------------------------------------------------------------
// cpu_rd_cache
// One-entry read cache for the CPU SDRAM responder. Tag is the word address
// (addr[ADDR_W-1:1]). Only built when M92_CPU_RDCACHE_EN is defined.
// Ports:
//   clk, reset         : clock, synchronous active-high reset (clears valid)
//   lookup_addr        : byte address of the access being considered
//   hit, hit_data      : entry valid and tag matches lookup_addr; cached word
//   fill_en/addr/data  : load the entry after a read miss completes
//   wr_en/addr/be/data : write that merges selected bytes on a tag match
// -----------------------------------------------------------------------------
module cpu_rd_cache
  import m92_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              fill_en,
  input  logic [ADDR_W-1:0] fill_addr,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [1:0]        wr_be,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int HALF = DATA_W / 2;

  logic              valid_q;
  logic [ADDR_W-2:0] tag_q;
  logic [DATA_W-1:0] data_q;

  assign hit      = valid_q && (tag_q == lookup_addr[ADDR_W-1:1]);
  assign hit_data = data_q;

  // Fill (WAIT) and write (IDLE launch) never occur in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (fill_en) begin
      valid_q <= 1'b1;
      tag_q   <= fill_addr[ADDR_W-1:1];
      data_q  <= fill_data;
    end else if (wr_en && valid_q && (tag_q == wr_addr[ADDR_W-1:1])) begin
      if (wr_be[1]) data_q[DATA_W-1:HALF] <= wr_data[DATA_W-1:HALF];
      if (wr_be[0]) data_q[HALF-1:0]      <= wr_data[HALF-1:0];
    end
  end

endmodule

// File: rtl/cpu_sdr_responder.sv
// -----------------------------------------------------------------------------
// cpu_sdr_responder
// Responder for ROM / work-RAM CPU cycles: runs the toggle request/ack
// handshake on the SDRAM CPU channel and returns read data plus a one-cycle
// cpu_ready pulse. Optional one-entry read cache: define M92_CPU_RDCACHE_EN.
//
// state | meaning
// IDLE  | waiting for a ROM/RAM strobe
// WAIT  | request toggled (or write discarded), waiting for completion
// DONE  | cpu_ready asserted for this single cycle
// HOLD  | waiting for the CPU to drop mem_rd/mem_wr
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   mem_rd, mem_wr             : CPU strobes, held until cpu_ready
//   rom_memrq, ram_memrq       : decoded SDRAM-backed selects
//   writable                   : region accepts writes
//   sdr_addr, cpu_be, cpu_dout : decoded address, byte enables, write data
//   cpu_din, cpu_ready         : read data and completion pulse to the CPU
//   sdr_req, sdr_ack           : request/acknowledge toggles
//   sdr_we, sdr_addr_out, sdr_be, sdr_wdata : latched request fields
//   sdr_rdata                  : SDRAM read data, valid on ack match
// -----------------------------------------------------------------------------
module cpu_sdr_responder
  import m92_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              rom_memrq,
  input  logic              ram_memrq,
  input  logic              writable,
  input  logic [ADDR_W-1:0] sdr_addr,
  input  logic [1:0]        cpu_be,
  input  logic [DATA_W-1:0] cpu_dout,
  output logic [DATA_W-1:0] cpu_din,
  output logic              cpu_ready,
  output logic              sdr_req,
  input  logic              sdr_ack,
  output logic              sdr_we,
  output logic [ADDR_W-1:0] sdr_addr_out,
  output logic [1:0]        sdr_be,
  output logic [DATA_W-1:0] sdr_wdata,
  input  logic [DATA_W-1:0] sdr_rdata
);

  cpu_sdr_state_e state, state_d;
  cpu_sdr_req_t   req_q;
  logic           sdr_req_q;
  logic [DATA_W-1:0] cpu_din_q;
  logic           drop_q;

  logic start;
  logic ack_match;
  logic launch;
  logic launch_we;
  logic drop_start;
  logic hit_take;
  logic rd_done;
  logic cache_hit;

  assign start     = (mem_rd | mem_wr) & (rom_memrq | ram_memrq);
  assign ack_match = (sdr_ack == sdr_req_q);
  // drop_q excludes the discarded-write pass through WAIT, where no request
  // is outstanding and sdr_rdata is meaningless.
  assign rd_done   = (state == WAIT) && ack_match && !drop_q && !req_q.we;

`ifdef M92_CPU_RDCACHE_EN
  logic [DATA_W-1:0] cache_data;

  cpu_rd_cache #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_cache (
    .clk         (clk),
    .reset       (reset),
    .lookup_addr (sdr_addr),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (rd_done),
    .fill_addr   (req_q.addr),
    .fill_data   (sdr_rdata),
    .wr_en       (launch & launch_we),
    .wr_addr     (sdr_addr),
    .wr_be       (cpu_be),
    .wr_data     (cpu_dout)
  );
`else
  assign cache_hit = 1'b0;
`endif

  // A write to a non-writable region goes through WAIT without toggling the
  // request, so it completes one cycle later than a cache hit.
  always_comb begin
    state_d    = state;
    launch     = 1'b0;
    launch_we  = 1'b0;
    drop_start = 1'b0;
    hit_take   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (mem_wr) begin
            if (writable) begin
              launch    = 1'b1;
              launch_we = 1'b1;
            end else begin
              drop_start = 1'b1;
            end
            state_d = WAIT;
          end else if (cache_hit) begin
            hit_take = 1'b1;
            state_d  = DONE;
          end else begin
            launch  = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (drop_q || ack_match) state_d = DONE;
      end
      DONE: state_d = HOLD;
      HOLD: begin
        if (!mem_rd && !mem_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      req_q     <= '0;
      sdr_req_q <= 1'b0;
      cpu_din_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state  <= state_d;
      drop_q <= drop_start;
      if (launch) begin
        req_q.addr <= {sdr_addr[ADDR_W-1:1], 1'b0};
        req_q.be   <= cpu_be;
        req_q.we   <= launch_we;
        if (launch_we) req_q.wdata <= cpu_dout;
        sdr_req_q  <= ~sdr_req_q;
      end
      if (rd_done) cpu_din_q <= sdr_rdata;
`ifdef M92_CPU_RDCACHE_EN
      if (hit_take) cpu_din_q <= cache_data;
`endif
    end
  end

  assign cpu_ready    = (state == DONE);
  assign cpu_din      = cpu_din_q;
  assign sdr_req      = sdr_req_q;
  assign sdr_we       = req_q.we;
  assign sdr_addr_out = req_q.addr;
  assign sdr_be       = req_q.be;
  assign sdr_wdata    = req_q.wdata;

endmodule
